fmul_rr_arbiter: RTL
====================

Name: fmul_rr_arbiter

Overview:
- Shares one half-precision floating-point multiplier (fm_half datapath: sign/exponent, booth, normalizer) between NREQ requesters.
- Selects one valid request per cycle using round-robin priority and registers its operands into the multiplier.
- Tracks the requester ID of each operation through the multiplier latency and routes each product back to the requester that issued it.
- Sits between the operand sources (block-RAM readers, test sequencers) and the single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 1, cycles from mul_valid to mul_p valid (0..4); 0 means the multiplier is combinational.
- ID_W, 2, requester-ID width, equal to clog2(NREQ).

Ports:
- clk  in  1  clock; all logic updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  accept enable; when low no new request is granted, and in-flight operations still complete.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  16*NREQ  operand A of requester i, at bits [16i+15:16i].
- req_b  in  16*NREQ  operand B of requester i, packed the same way.
- req_ready  out  NREQ  one-hot grant, combinational.
- mul_valid  out  1  registered; operands are issued this cycle.
- mul_a  out  16  registered operand A to the multiplier.
- mul_b  out  16  registered operand B to the multiplier.
- mul_p  in  16  product {sign, exponent[4:0], mantissa[9:0]} from the multiplier.
- rsp_valid  out  NREQ  registered one-hot response strobe.
- rsp_data  out  16  registered product; valid only when rsp_valid != 0.
- inflight  out  4  registered count of issued but not yet responded operations.

Behaviour:
- Reset values:
  - req_ready=0, mul_valid=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_data=0, inflight=0.
  - Priority pointer ptr=0.
  - ID/valid delay line cleared.
- Arbitration (combinational):
  - If rst=0 and en=1, grant the first i with req_valid[i]=1, scanning ptr, ptr+1, ... NREQ-1, 0, ... ptr-1 (modulo NREQ).
  - req_ready has at most one bit set. With no valid request, req_ready=0.
  - req_ready never depends on a requester's own req_ready. A requester may drop req_valid at any time before acceptance.
- Acceptance: handshake at edge E when req_valid[i] & req_ready[i]. At E:
  - mul_a<=req_a[i], mul_b<=req_b[i], mul_valid<=1.
  - ptr<=(i+1) mod NREQ; wrap from NREQ-1 to 0.
- No acceptance: mul_valid<=0, mul_a/mul_b hold their values, ptr holds.
- Throughput and ordering:
  - One operation per cycle, with no bubbles between back-to-back accepts.
  - Results return in issue order.
- ID tracking: a delay line of MUL_LAT stages carries {valid, id}, aligned so that the entry matching the cycle mul_p is valid is available that cycle.
- Response:
  - In the cycle mul_p is valid for the operation from requester i, at the next edge: rsp_valid<=onehot(i), rsp_data<=mul_p.
  - Otherwise rsp_valid<=0 and rsp_data holds its value.
- Latency: accept edge E, then mul_valid high during cycle E+1, then rsp_valid high during cycle E+2+MUL_LAT. Total MUL_LAT+2 edges from acceptance.
- Backpressure: responses cannot be back-pressured. A requester must sample rsp_data in the single cycle its rsp_valid bit is set.
- inflight:
  - Increments on accept and decrements on response emission.
  - Simultaneous accept and response: holds.
  - Maximum value is MUL_LAT+2, so it never saturates.
- en=0 mid-stream: the pipeline drains normally and inflight reaches 0 after MUL_LAT+2 cycles.
- rst mid-operation:
  - All in-flight operations are discarded and no rsp_valid is produced for them.
  - All state returns to its reset values at that edge.
  - req_ready=0 while rst=1.
- Data contents: mul_p is passed through unmodified. Zero, subnormal and overflow values are not special-cased.

Test Plan:
- Single request: rst released, req_valid=4'b0001, req_a=16'h3E00 (1.5), req_b=16'h4000 (2.0), multiplier model returns 16'h4200.
  - Required: req_ready=4'b0001 in the same cycle.
  - Required: mul_valid at +1 with mul_a=16'h3E00, mul_b=16'h4000.
  - Required: rsp_valid=4'b0001 and rsp_data=16'h4200 at +(MUL_LAT+2); inflight 1, then 0.
- All four requesters hold valid for 8 cycles after reset.
  - Required grant order 0,1,2,3,0,1,2,3 with one grant per cycle.
  - Required: rsp_valid sequence matches the grant order, each paired with the correct product.
- Wrap and skip: ptr=3 after granting requester 2, then req_valid=4'b0101.
  - Required grant order: 0, then 2, then 0 (requester 3 is skipped while idle).
- en=0 for 5 cycles with all requesters valid:
  - Required: req_ready=0 and mul_valid=0 throughout.
  - Required: earlier in-flight operations still respond, and inflight drains to 0.
- Reset mid-flight: rst asserted for 1 cycle while inflight=3.
  - Required: no rsp_valid afterwards for those operations, and inflight=0.
  - Required: the next grant goes to requester 0.
- Repeat the single-request and all-requesters scenarios with MUL_LAT=0 and MUL_LAT=4.
  - Required response latency: 2 and 6 edges respectively.
  - Required: back-to-back throughput stays at 1 per cycle.

Source files
------------

// File: rtl/fmul_rr_arbiter.sv
// rtl/fmul_rr_arbiter.sv - round-robin arbiter sharing one fp16 multiplier among NREQ requesters
// Grants one request per cycle, issues registered operands and routes each product back by ID.
module fmul_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 mul_valid,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_p,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_data,
  output logic [3:0]           inflight
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  int              idx;

  // Stage 0 is the issue register (mirrors mul_valid); stage MUL_LAT lines up with mul_p.
  logic [MUL_LAT:0] pv;
  logic [ID_W-1:0]  pid [MUL_LAT+1];

  always_comb begin
    gnt_any   = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    idx       = 0;
    if (!rst && en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = ID_W'(idx);
        end
      end
    end
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  assign mul_valid = pv[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      pv        <= '0;
      for (int k = 0; k <= MUL_LAT; k++) pid[k] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      inflight  <= '0;
    end else begin
      pv[0] <= gnt_any;
      if (gnt_any) begin
        mul_a  <= req_a[{gnt_id, 4'b0000} +: 16];
        mul_b  <= req_b[{gnt_id, 4'b0000} +: 16];
        pid[0] <= gnt_id;
        ptr    <= (gnt_id == ID_W'(NREQ-1)) ? '0 : ID_W'(gnt_id + 1'b1);
      end
      for (int k = 1; k <= MUL_LAT; k++) begin
        pv[k]  <= pv[k-1];
        pid[k] <= pid[k-1];
      end
      if (pv[MUL_LAT]) begin
        rsp_valid <= NREQ'(1) << pid[MUL_LAT];
        rsp_data  <= mul_p;
      end else begin
        rsp_valid <= '0;
      end
      // An operation stays counted through the cycle its rsp_valid is visible.
      inflight <= 4'(inflight + {3'b000, gnt_any} - {3'b000, |rsp_valid});
    end
  end

endmodule
